// File: rtl/data_distributor.sv
// 1-to-2 sequential data distributor: each incoming word goes to the S or T branch,
// and each branch has its own 2-entry FIFO, valid/ready output and pop counter.

module data_distributor_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             space_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] cnt_o
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop;

    assign pop = valid_q && ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push_i) state_d = ONE;
            ONE: begin
                if (push_i && !pop)      state_d = FULL;
                else if (pop && !push_i) state_d = EMPTY;
            end
            FULL:    if (pop && !push_i) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            valid_q  <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != EMPTY);
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
        end
    end

    // A full FIFO can still take a word in the same cycle its head leaves.
    assign space_o = (state_q != FULL) || ready_i;
    assign data_o  = valid_q ? mem_q[rd_ptr_q] : '0;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;
endmodule

module data_distributor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In,
    input  logic             Ctrl,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] OutS,
    output logic             OutSValid,
    input  logic             OutSReady,
    output logic [WIDTH-1:0] OutT,
    output logic             OutTValid,
    input  logic             OutTReady,
    output logic [CNT_W-1:0] CntS,
    output logic [CNT_W-1:0] CntT
);
    logic s_space, t_space;
    logic push_s, push_t;

    // Head-of-line: readiness follows only the selected branch.
    assign InReady = Ctrl ? t_space : s_space;
    assign push_s  = InValid && InReady && !Ctrl;
    assign push_t  = InValid && InReady && Ctrl;

    data_distributor_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo_s (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .data_i  (In),
        .space_o (s_space),
        .data_o  (OutS),
        .valid_o (OutSValid),
        .ready_i (OutSReady),
        .cnt_o   (CntS)
    );

    data_distributor_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo_t (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_t),
        .data_i  (In),
        .space_o (t_space),
        .data_o  (OutT),
        .valid_o (OutTValid),
        .ready_i (OutTReady),
        .cnt_o   (CntT)
    );
endmodule

// File: tb/tb_data_distributor.sv
// Directed bench for data_distributor, using 4-bit counters so that wrap-around is reachable.

module tb_data_distributor;
    logic        clk;
    logic        rst;
    logic [31:0] In;
    logic        Ctrl;
    logic        InValid;
    logic        InReady;
    logic [31:0] OutS;
    logic        OutSValid;
    logic        OutSReady;
    logic [31:0] OutT;
    logic        OutTValid;
    logic        OutTReady;
    logic [3:0]  CntS;
    logic [3:0]  CntT;

    int tests;
    int fails;

    data_distributor #(.WIDTH(32), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .In        (In),
        .Ctrl      (Ctrl),
        .InValid   (InValid),
        .InReady   (InReady),
        .OutS      (OutS),
        .OutSValid (OutSValid),
        .OutSReady (OutSReady),
        .OutT      (OutT),
        .OutTValid (OutTValid),
        .OutTReady (OutTReady),
        .CntS      (CntS),
        .CntT      (CntT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset held for two edges while a word is offered.
        rst = 1'b1; InValid = 1'b1; In = 32'hdead_beef; Ctrl = 1'b0;
        OutSReady = 1'b0; OutTReady = 1'b0;
        tick();
        tick();
        rst = 1'b0; InValid = 1'b0;
        #1;
        chk("rst_svalid", 32'(OutSValid), 32'd0);
        chk("rst_tvalid", 32'(OutTValid), 32'd0);
        chk("rst_outs", OutS, 32'd0);
        chk("rst_outt", OutT, 32'd0);
        chk("rst_cnts", 32'(CntS), 32'd0);
        chk("rst_cntt", 32'(CntT), 32'd0);
        chk("rst_inready", 32'(InReady), 32'd1);

        // Routing: one word to S, then one to T.
        OutSReady = 1'b1; OutTReady = 1'b1;
        In = 32'h0000_ffff; Ctrl = 1'b0; InValid = 1'b1;
        #1;
        chk("route_rdy", 32'(InReady), 32'd1);
        tick();
        In = 32'h0000_5555; Ctrl = 1'b1;
        #1;
        chk("route_outs", OutS, 32'h0000_ffff);
        chk("route_svalid", 32'(OutSValid), 32'd1);
        chk("route_tvalid0", 32'(OutTValid), 32'd0);
        tick();
        InValid = 1'b0;
        #1;
        chk("route_outt", OutT, 32'h0000_5555);
        chk("route_tvalid", 32'(OutTValid), 32'd1);
        chk("route_s_gone", 32'(OutSValid), 32'd0);
        chk("route_outs_mask", OutS, 32'd0);
        chk("route_cnts", 32'(CntS), 32'd1);
        tick();
        chk("route_cntt", 32'(CntT), 32'd1);
        chk("route_t_gone", 32'(OutTValid), 32'd0);

        // Fill S with its consumer stalled.
        OutSReady = 1'b0;
        InValid = 1'b1; Ctrl = 1'b0; In = 32'd1;
        tick();
        In = 32'd2;
        #1;
        chk("fill_rdy2", 32'(InReady), 32'd1);
        tick();
        In = 32'd3;
        #1;
        chk("fill_rdy3", 32'(InReady), 32'd0);
        chk("fill_head", OutS, 32'd1);
        tick();
        chk("fill_hold_rdy", 32'(InReady), 32'd0);
        chk("fill_hold_head", OutS, 32'd1);

        // Head-of-line: T still accepts while S is full and stalled.
        Ctrl = 1'b1; In = 32'h0000_5555;
        #1;
        chk("hol_t_rdy", 32'(InReady), 32'd1);
        tick();
        Ctrl = 1'b0; In = 32'd3;
        #1;
        chk("hol_outt", OutT, 32'h0000_5555);
        chk("hol_tvalid", 32'(OutTValid), 32'd1);
        chk("hol_s_rdy", 32'(InReady), 32'd0);
        OutSReady = 1'b1;
        #1;
        chk("fill_popush_rdy", 32'(InReady), 32'd1);
        tick();
        InValid = 1'b0;
        #1;
        chk("fill_out2", OutS, 32'd2);
        chk("fill_cnts2", 32'(CntS), 32'd2);
        chk("hol_cntt", 32'(CntT), 32'd2);
        chk("hol_t_gone", 32'(OutTValid), 32'd0);
        tick();
        chk("fill_out3", OutS, 32'd3);
        chk("fill_cnts3", 32'(CntS), 32'd3);
        tick();
        chk("fill_empty", 32'(OutSValid), 32'd0);
        chk("fill_cnts4", 32'(CntS), 32'd4);

        // Full rate with Ctrl alternating: even words to S, odd words to T.
        OutSReady = 1'b1; OutTReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            In = 32'(i); Ctrl = i[0]; InValid = 1'b1;
            #1;
            chk("alt_rdy", 32'(InReady), 32'd1);
            if (i > 0) begin
                if (i[0]) chk("alt_outs", OutS, 32'(i - 1));
                else      chk("alt_outt", OutT, 32'(i - 1));
            end
            tick();
        end
        InValid = 1'b0;
        #1;
        chk("alt_last", OutT, 32'd99);
        tick();
        chk("alt_cnts", 32'(CntS), 32'd6);   // (4 + 50) mod 16
        chk("alt_cntt", 32'(CntT), 32'd4);   // (2 + 50) mod 16

        // Counter wrap on T, starting from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrap_rst_cntt", 32'(CntT), 32'd0);
        Ctrl = 1'b1; InValid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            In = 32'(100 + i);
            tick();
        end
        InValid = 1'b0;
        chk("wrap_zero", 32'(CntT), 32'd0);
        chk("wrap_last", OutT, 32'd116);
        tick();
        chk("wrap_cntt", 32'(CntT), 32'd1);
        chk("wrap_tvalid", 32'(OutTValid), 32'd0);

        // Reset mid-operation with S holding two words.
        OutSReady = 1'b0;
        Ctrl = 1'b0; InValid = 1'b1; In = 32'h0000_00a1;
        tick();
        In = 32'h0000_00a2;
        tick();
        chk("mid_svalid", 32'(OutSValid), 32'd1);
        chk("mid_full", 32'(InReady), 32'd0);
        rst = 1'b1; InValid = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_svalid0", 32'(OutSValid), 32'd0);
        chk("mid_outs0", OutS, 32'd0);
        chk("mid_cnts", 32'(CntS), 32'd0);
        chk("mid_cntt", 32'(CntT), 32'd0);
        chk("mid_rdy", 32'(InReady), 32'd1);
        InValid = 1'b1; In = 32'h0000_00c3;
        tick();
        InValid = 1'b0;
        chk("mid_repush", OutS, 32'h0000_00c3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
